// File: rtl/vid_pkg.sv
// Shared types and constants for the text VRAM fetch path.
package vid_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int CHAR_W   = 8;
  localparam int COLS_W   = 7;
  localparam int RASTER_W = 3;

  // Slot phases: address out, code in / CG address out, pattern in, shifter load.
  localparam logic [2:0] PH_VA   = 3'd0;
  localparam logic [2:0] PH_CGA  = 3'd1;
  localparam logic [2:0] PH_CGD  = 3'd3;
  localparam logic [2:0] PH_LOAD = 3'd7;

  function automatic logic [CHAR_W+RASTER_W-1:0] cg_addr(
    input logic [CHAR_W-1:0]   code,
    input logic [RASTER_W-1:0] raster
  );
    return {code, raster};
  endfunction

endpackage

// File: rtl/text_vram_fetch_if.sv
// Bus bundle between the CRTC/VRAM/CG ROM side and the text fetcher.
interface text_vram_fetch_if #(
  parameter int ADDR_W = 11
);
  logic              PCE;
  logic              FS;
  logic              LS;
  logic [ADDR_W-1:0] START_ADDR;
  logic [6:0]        COLS;
  logic [ADDR_W-1:0] VA;
  logic [7:0]        VDO;
  logic [10:0]       CG_A;
  logic [7:0]        CG_D;
  logic              PIX;
  logic              DE_OUT;

  // The fetcher issues VRAM/CG addresses and pixels.
  modport master (
    input  PCE, FS, LS, START_ADDR, COLS, VDO, CG_D,
    output VA, CG_A, PIX, DE_OUT
  );

  // Timing generator, memories and pixel mixer.
  modport slave (
    output PCE, FS, LS, START_ADDR, COLS, VDO, CG_D,
    input  VA, CG_A, PIX, DE_OUT
  );
endinterface

// File: rtl/text_shifter.sv
// 8-bit pixel shifter with a down-counting pixel budget that produces DE.
module text_shifter
  import vid_pkg::*;
#(
  parameter int CNT_W = COLS_W + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pce,
  input  logic              clr,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              load,
  input  logic [CHAR_W-1:0] data,
  output logic              pix,
  output logic              de,
  output logic              last
);

  logic [CHAR_W-1:0] shreg;
  logic [CNT_W-1:0]  pix_cnt;

  // Load or shift the pattern and count down the remaining visible pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      pix_cnt <= '0;
    end else if (pce) begin
      if (clr) begin
        shreg   <= '0;
        pix_cnt <= '0;
      end else begin
        if (start)
          pix_cnt <= count;
        else if (pix_cnt != '0)
          pix_cnt <= pix_cnt - CNT_W'(1);
        if (load)
          shreg <= data;
        else
          shreg <= {shreg[CHAR_W-2:0], 1'b0};
      end
    end
  end

  assign de   = (pix_cnt != '0);
  assign last = (pix_cnt == CNT_W'(1));
  // Gate with DE so an aborted or finished line never leaks a stale bit.
  assign pix  = shreg[CHAR_W-1] & de;

endmodule

// File: rtl/text_vram_fetch.sv
// Text VRAM reader: walks character addresses, looks up CG patterns and
// feeds the pixel shifter one character slot (8 enabled cycles) ahead.
//
//   state  | meaning
//   IDLE   | between lines, waiting for LS
//   PRIME  | first slot of a line: fetch char 0, nothing displayed yet
//   ACTIVE | pixels shifting out while the next character is fetched
module text_vram_fetch
  import vid_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int RASTER_MAX = 7
) (
  input logic               VCLK,
  input logic               VRST_N,
  text_vram_fetch_if.master bus
);

  localparam int CNT_W = COLS_W + 3;
  localparam logic [RASTER_W-1:0] RASTER_LAST = RASTER_W'(RASTER_MAX);

  state_t                     state;
  logic [2:0]                 phase;
  logic [ADDR_W-1:0]          row_base;
  logic [ADDR_W-1:0]          va;
  logic [COLS_W-1:0]          idx;
  logic [COLS_W-1:0]          cols_lat;
  logic [RASTER_W-1:0]        raster;
  logic [CHAR_W+RASTER_W-1:0] cg_a;
  logic [CHAR_W-1:0]          pattern_hold;
  logic                       fetch_ok;

  logic                       sh_clr;
  logic                       sh_start;
  logic                       sh_load;
  logic                       sh_last;
  logic                       sh_pix;
  logic                       sh_de;
  logic [CNT_W-1:0]           sh_count;
  logic [ADDR_W-1:0]          idx_ext;
  logic [ADDR_W-1:0]          cols_ext;

  assign idx_ext  = ADDR_W'(idx);
  assign cols_ext = ADDR_W'(cols_lat);
  assign sh_count = {cols_lat, 3'b000};

  // Shifter control: any FS/LS aborts the line; slot end loads the next pattern.
  always_comb begin
    sh_clr   = 1'b0;
    sh_start = 1'b0;
    sh_load  = 1'b0;
    if (bus.FS || bus.LS) begin
      sh_clr = 1'b1;
    end else if (state == PRIME && phase == PH_LOAD) begin
      sh_start = 1'b1;
      sh_load  = 1'b1;
    end else if (state == ACTIVE && phase == PH_LOAD && !sh_last) begin
      sh_load = 1'b1;
    end
  end

  // Line sequencing, fetch pipeline and raster/row bookkeeping.
  always_ff @(posedge VCLK) begin
    if (!VRST_N) begin
      state        <= IDLE;
      phase        <= PH_VA;
      row_base     <= '0;
      va           <= '0;
      idx          <= '0;
      cols_lat     <= '0;
      raster       <= '0;
      cg_a         <= '0;
      pattern_hold <= '0;
      fetch_ok     <= 1'b0;
    end else if (bus.PCE) begin
      // Frame start lands first so a coincident LS sees the new row_base.
      if (bus.FS) begin
        row_base <= bus.START_ADDR;
        raster   <= '0;
      end
      if (bus.LS) begin
        idx      <= '0;
        cols_lat <= bus.COLS;
        phase    <= PH_VA;
        fetch_ok <= 1'b0;
        state    <= (bus.COLS != '0) ? PRIME : IDLE;
      end else if (bus.FS) begin
        state    <= IDLE;
        phase    <= PH_VA;
        fetch_ok <= 1'b0;
      end else if (state != IDLE) begin
        phase <= phase + 3'd1;
        if (phase == PH_VA) begin
          if (idx < cols_lat) begin
            va       <= row_base + idx_ext;
            idx      <= idx + COLS_W'(1);
            fetch_ok <= 1'b1;
          end else begin
            fetch_ok <= 1'b0;
          end
        end
        if (phase == PH_CGA && fetch_ok)
          cg_a <= cg_addr(bus.VDO, raster);
        if (phase == PH_CGD && fetch_ok)
          pattern_hold <= bus.CG_D;
        if (state == PRIME && phase == PH_LOAD)
          state <= ACTIVE;
        if (state == ACTIVE && sh_last) begin
          state <= IDLE;
          phase <= PH_VA;
          if (raster == RASTER_LAST) begin
            raster   <= '0;
            row_base <= row_base + cols_ext;
          end else begin
            raster <= raster + RASTER_W'(1);
          end
        end
      end
    end
  end

  text_shifter #(
    .CNT_W(CNT_W)
  ) u_shifter (
    .clk   (VCLK),
    .rst_n (VRST_N),
    .pce   (bus.PCE),
    .clr   (sh_clr),
    .start (sh_start),
    .count (sh_count),
    .load  (sh_load),
    .data  (pattern_hold),
    .pix   (sh_pix),
    .de    (sh_de),
    .last  (sh_last)
  );

  assign bus.VA     = va;
  assign bus.CG_A   = cg_a;
  assign bus.PIX    = sh_pix;
  assign bus.DE_OUT = sh_de;

endmodule

// File: tb/tb_text_vram_fetch.sv
// Directed bench for text_vram_fetch: vector table plus hand-written sequences.
module tb_text_vram_fetch;

  logic VCLK;
  logic VRST_N;

  text_vram_fetch_if #(.ADDR_W(11)) bus ();

  text_vram_fetch #(
    .ADDR_W(11),
    .RASTER_MAX(7)
  ) dut (
    .VCLK   (VCLK),
    .VRST_N (VRST_N),
    .bus    (bus)
  );

  initial VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  // Memory models: VRAM and CG ROM answer within the cycle after the address.
  logic [7:0] vram [0:2047];

  function automatic logic [7:0] cg_fn(input logic [10:0] a);
    return a[10:3] ^ {5'b00000, a[2:0]};
  endfunction

  assign bus.VDO  = vram[bus.VA];
  assign bus.CG_D = cg_fn(bus.CG_A);

  typedef struct {
    logic        fs;
    logic        ls;
    logic [10:0] va;
    logic [10:0] cga;
    logic        pix;
    logic        de;
  } vec_t;

  vec_t vt [0:29];

  int checks = 0;
  int errors = 0;

  logic [10:0] va_q  [$];
  logic [10:0] cga_q [$];
  logic        pix_q [$];
  int          de_cnt;
  int          first_de;
  logic        done;
  logic [10:0] wrap_exp [0:3];
  logic [15:0] exp_bits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge VCLK);
    #1;
  endtask

  task automatic fs_tick(input logic [10:0] addr);
    bus.FS = 1'b1;
    bus.START_ADDR = addr;
    tick();
    bus.FS = 1'b0;
  endtask

  task automatic ls_tick(input logic [6:0] cols);
    bus.LS = 1'b1;
    bus.COLS = cols;
    tick();
    bus.LS = 1'b0;
  endtask

  // Run enabled cycles until DE falls; n counts edges since LS acceptance.
  task automatic collect(input int n0, input int limit, output logic fin);
    int   n;
    logic seen;
    va_q.delete();
    cga_q.delete();
    pix_q.delete();
    de_cnt = 0;
    first_de = -1;
    fin = 1'b0;
    seen = 1'b0;
    n = n0;
    for (int k = 0; k < limit; k++) begin
      tick();
      n++;
      if (n % 8 == 1) va_q.push_back(bus.VA);
      if (n % 8 == 2) cga_q.push_back(bus.CG_A);
      if (bus.DE_OUT) begin
        if (first_de < 0) first_de = n;
        de_cnt++;
        pix_q.push_back(bus.PIX);
        seen = 1'b1;
      end else if (seen) begin
        fin = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2048; i++) vram[i] = 8'(i) + 8'h20;
    vram[11'h100] = 8'h41;
    vram[11'h101] = 8'h42;
    wrap_exp[0] = 11'h7FE;
    wrap_exp[1] = 11'h7FF;
    wrap_exp[2] = 11'h000;
    wrap_exp[3] = 11'h001;

    // FS@0x100, LS COLS=2: VA/CG_A pipeline, 16 pixels of 0x41,0x42, next line raster 1.
    vt[0]  = '{1'b1, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 11'h000, 11'h000, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 11'h100, 11'h000, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 11'h100, 11'h208, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 11'h100, 11'h208, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 11'h100, 11'h208, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 11'h100, 11'h208, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 11'h100, 11'h208, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 11'h100, 11'h208, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 11'h100, 11'h208, 1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b0, 11'h101, 11'h208, 1'b1, 1'b1};
    vt[11] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[13] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[14] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[15] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[16] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b1, 1'b1};
    vt[17] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[18] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b1, 1'b1};
    vt[19] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[20] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[21] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[22] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[23] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b1, 1'b1};
    vt[24] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b1};
    vt[25] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b0};
    vt[26] = '{1'b0, 1'b0, 11'h101, 11'h210, 1'b0, 1'b0};
    vt[27] = '{1'b0, 1'b1, 11'h101, 11'h210, 1'b0, 1'b0};
    vt[28] = '{1'b0, 1'b0, 11'h100, 11'h210, 1'b0, 1'b0};
    vt[29] = '{1'b0, 1'b0, 11'h100, 11'h209, 1'b0, 1'b0};

    VRST_N = 1'b0;
    bus.PCE = 1'b1;
    bus.FS = 1'b0;
    bus.LS = 1'b0;
    bus.START_ADDR = 11'h000;
    bus.COLS = 7'd0;
    repeat (3) tick();
    chk("rst_va",  32'(bus.VA),     32'h0);
    chk("rst_cga", 32'(bus.CG_A),   32'h0);
    chk("rst_pix", 32'(bus.PIX),    32'h0);
    chk("rst_de",  32'(bus.DE_OUT), 32'h0);
    VRST_N = 1'b1;

    for (int i = 0; i < 30; i++) begin
      bus.FS = vt[i].fs;
      bus.LS = vt[i].ls;
      bus.START_ADDR = 11'h100;
      bus.COLS = 7'd2;
      tick();
      chk($sformatf("vec%0d_va", i),  32'(bus.VA),     32'(vt[i].va));
      chk($sformatf("vec%0d_cga", i), 32'(bus.CG_A),   32'(vt[i].cga));
      chk($sformatf("vec%0d_pix", i), 32'(bus.PIX),    32'(vt[i].pix));
      chk($sformatf("vec%0d_de", i),  32'(bus.DE_OUT), 32'(vt[i].de));
    end
    bus.FS = 1'b0;
    bus.LS = 1'b0;

    // Reset held 3 cycles in the middle of an active line.
    repeat (10) tick();
    chk("midline_de_before", 32'(bus.DE_OUT), 32'h1);
    VRST_N = 1'b0;
    repeat (3) tick();
    chk("midrst_va",  32'(bus.VA),     32'h0);
    chk("midrst_cga", 32'(bus.CG_A),   32'h0);
    chk("midrst_pix", 32'(bus.PIX),    32'h0);
    chk("midrst_de",  32'(bus.DE_OUT), 32'h0);
    VRST_N = 1'b1;
    ls_tick(7'd1);
    collect(0, 100, done);
    chk("postrst_done", 32'(done), 32'h1);
    if (done) begin
      chk("postrst_va",  32'(va_q[0]),  32'h000);
      chk("postrst_cga", 32'(cga_q[0]), 32'h100);
      chk("postrst_de",  32'(de_cnt),   32'd8);
      chk("postrst_lat", 32'(first_de), 32'd8);
    end

    // Eight 40-column lines step the raster, the ninth advances the row.
    fs_tick(11'h000);
    for (int l = 0; l < 9; l++) begin
      ls_tick(7'd40);
      collect(0, 1000, done);
      chk($sformatf("row%0d_done", l), 32'(done), 32'h1);
      if (done) begin
        chk($sformatf("row%0d_va", l), 32'(va_q[0]), (l == 8) ? 32'h028 : 32'h000);
        chk($sformatf("row%0d_cga", l), 32'(cga_q[0]),
            (l == 8) ? 32'({8'h48, 3'd0}) : 32'({8'h20, 3'(l)}));
        if (l == 0) begin
          chk("row0_de",  32'(de_cnt),   32'd320);
          chk("row0_lat", 32'(first_de), 32'd8);
        end
      end
    end

    // Address wrap across the top of VRAM.
    fs_tick(11'h7FE);
    ls_tick(7'd4);
    collect(0, 200, done);
    chk("wrap_done", 32'(done), 32'h1);
    if (done) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("wrap_va%0d", i), 32'(va_q[i]), 32'(wrap_exp[i]));
      chk("wrap_de", 32'(de_cnt), 32'd32);
    end

    // PCE toggling: same pixels, each held for two VCLKs.
    fs_tick(11'h100);
    ls_tick(7'd2);
    exp_bits = 16'h4142;
    pix_q.delete();
    for (int c = 0; c < 80; c++) begin
      bus.PCE = (c % 2 == 1);
      tick();
      if (bus.DE_OUT) pix_q.push_back(bus.PIX);
    end
    bus.PCE = 1'b1;
    chk("pce_de_span", 32'(pix_q.size()), 32'd32);
    if (pix_q.size() == 32) begin
      for (int j = 0; j < 32; j++)
        chk($sformatf("pce_pix%0d", j), 32'(pix_q[j]), 32'(exp_bits[15 - j / 2]));
    end

    // LS reasserted at pixel 5: line restarts at row_base on the same raster.
    fs_tick(11'h100);
    ls_tick(7'd2);
    collect(0, 100, done);
    chk("abort_pre_done", 32'(done), 32'h1);
    ls_tick(7'd2);
    repeat (13) tick();
    chk("abort_de_before", 32'(bus.DE_OUT), 32'h1);
    chk("abort_va_before", 32'(bus.VA), 32'h101);
    ls_tick(7'd2);
    chk("abort_de_drop", 32'(bus.DE_OUT), 32'h0);
    tick();
    chk("abort_refetch_va", 32'(bus.VA), 32'h100);
    tick();
    chk("abort_refetch_cga", 32'(bus.CG_A), 32'h209);
    collect(2, 100, done);
    chk("abort_done", 32'(done), 32'h1);
    chk("abort_de", 32'(de_cnt), 32'd16);
    ls_tick(7'd2);
    collect(0, 100, done);
    chk("abort_next_done", 32'(done), 32'h1);
    if (done) chk("abort_next_cga", 32'(cga_q[0]), 32'h20A);

    // FS and LS in the same enabled cycle.
    bus.FS = 1'b1;
    bus.LS = 1'b1;
    bus.START_ADDR = 11'h300;
    bus.COLS = 7'd1;
    tick();
    bus.FS = 1'b0;
    bus.LS = 1'b0;
    collect(0, 100, done);
    chk("fsls_done", 32'(done), 32'h1);
    if (done) begin
      chk("fsls_va",  32'(va_q[0]),  32'h300);
      chk("fsls_cga", 32'(cga_q[0]), 32'h100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
